// File: rtl/fib_stack.sv
// fib_stack: LIFO operand stack for the recursive Fibonacci engine.
// Takes push/pop/clear strobes from the controller and returns the empty/full
// status. Top-of-stack goes to the datapath. Every output is a decode of
// registered state, so there is no combinational path from push, pop or din
// to any output.
module fib_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [PTR_W:0]   count,
  output logic             ovf,
  output logic             unf
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W:0]   r_count;
  logic             r_ovf;
  logic             r_unf;

  logic             w_empty;
  logic             w_full;
  logic [PTR_W:0]   w_cnt_m1;
  logic             w_wr_en;
  logic [PTR_W-1:0] w_wr_idx;

  // Status decodes and the write slot.
  // A replace (push & pop on a non-empty stack) overwrites the current top.
  // Every other write lands one slot above it. When push and pop arrive
  // together on an empty stack, count is 0, so the write goes to slot 0.
  always_comb begin
    w_empty  = (r_count == '0);
    w_full   = (r_count == (PTR_W+1)'(DEPTH));
    w_cnt_m1 = r_count - (PTR_W+1)'(1);
    w_wr_en  = !clr && push && (pop || !w_full);
    w_wr_idx = (pop && !w_empty) ? w_cnt_m1[PTR_W-1:0] : r_count[PTR_W-1:0];
  end

  // Storage array, with no reset.
  // Any slot at or above count is always written before it can become the
  // top, so stale contents left over from reset are never visible.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[w_wr_idx] <= din;
  end

  // Count and sticky error flags. Priority: clr, then push&pop, then push, then pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (clr) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (push && pop) begin
      if (w_empty) r_count <= (PTR_W+1)'(1);
    end else if (push) begin
      if (w_full) r_ovf   <= 1'b1;
      else        r_count <= r_count + (PTR_W+1)'(1);
    end else if (pop) begin
      if (w_empty) r_unf   <= 1'b1;
      else         r_count <= w_cnt_m1;
    end
  end

  // Output drive, all from registered state.
  always_comb begin
    dout  = w_empty ? '0 : r_mem[w_cnt_m1[PTR_W-1:0]];
    empty = w_empty;
    full  = w_full;
    count = r_count;
    ovf   = r_ovf;
    unf   = r_unf;
  end

endmodule

// File: doc/fib_stack.md
Name: fib_stack

Overview:
- LIFO operand stack for the recursive Fibonacci engine; sits directly downstream of the Fibonacci controller.
- Consumes the controller's push/pop/clear strobes.
- Returns the empty status that steers the controller's next-state logic.
- Supplies top-of-stack to the datapath adder/comparator.

Parameters:
WIDTH, 8, data word width in bits
DEPTH, 16, number of entries; must be a power of 2
PTR_W, 4, log2(DEPTH)

Ports:
clk  input  1  rising-edge clock shared with controller and datapath
rst  input  1  asynchronous reset, active-low
clr  input  1  synchronous clear (driven by the controller's rst strobe); empties the stack
push  input  1  write din to new top on this clock edge
pop  input  1  discard top entry on this clock edge
din  input  WIDTH  data to push
dout  output  WIDTH  current top-of-stack, combinational from stored state; 0 when empty
empty  output  1  high when count == 0
full  output  1  high when count == DEPTH
count  output  PTR_W+1  number of valid entries, 0..DEPTH
ovf  output  1  sticky: a push was attempted while full
unf  output  1  sticky: a pop was attempted while empty

Behaviour:
- Storage: DEPTH x WIDTH register array plus PTR_W+1-bit count register. All state updates on rising clk.
- Asynchronous reset (rst low): count=0, ovf=0, unf=0 immediately, independent of clk. Outputs: empty=1, full=0, dout=0. Array contents are not cleared and are don't-care.
- Reset release: first active edge is the first clk rise with rst high.
- Command priority per edge: clr > (push & pop) > push > pop.
- clr=1: count<=0, ovf<=0, unf<=0. push/pop ignored that cycle. Array untouched.
- push only, not full: mem[count]<=din, count<=count+1.
- push only, full: no state change except ovf<=1.
- pop only, not empty: count<=count-1. The entry is not erased.
- pop only, empty: no state change except unf<=1.
- push & pop, not empty (replace top): mem[count-1]<=din; count unchanged; no flags set, including when full.
- push & pop, empty: behaves as push only (count<=1, mem[0]<=din); unf not set.
- dout = mem[count-1] when count>0, else 0. Reflects the new top in the cycle after any push/pop/replace, i.e. 1-cycle write-to-read latency, no extra pipeline.
- empty and full are pure decodes of count. They change in the same cycle as count, so the controller sees the new empty on the next edge.
- ovf/unf stay set until clr or rst; further errors keep them at 1.
- count never wraps: saturates at DEPTH on overflow attempt, holds at 0 on underflow attempt.
- Reset asserted mid-operation overrides any command on that edge. The stack is empty once rst is low.
- No combinational path from push/pop/din to dout, empty, full or count. All outputs derive from registered state only.

Test Plan:
- Reset: drive rst=0 at t=0, hold push=1 din=8'hAA for 3 clocks -> count=0, empty=1, full=0, dout=0, ovf=unf=0 throughout. Release rst and idle 1 clock -> still empty.
- Ordering: push 8'h01, 8'h02, 8'h03 on consecutive edges -> count=3, dout=03. Then pop x3 -> dout 02, 01, 0; empty=1 after the third pop.
- Full/overflow: push 16 values 8'h10..8'h1F -> full=1, count=16, dout=1F. A 17th push of 8'hFF -> count=16, dout=1F, ovf=1. Then pop -> dout=1E, full=0, ovf stays 1.
- Underflow and empty+replace: from empty, pop -> unf=1, count=0. Then push&pop din=8'h55 from empty -> count=1, dout=55. Then push&pop din=8'h66 -> count=1, dout=66.
- clr priority: with count=5 and ovf=1, assert clr with push=1 -> next cycle count=0, empty=1, ovf=0, dout=0. A following push 8'h77 -> dout=77, count=1.
- Async reset mid-run: with count=7, drop rst midway between edges -> count=0 and empty=1 before the next clk rise. No update on edges while rst is low.
